// File: rtl/amo_sequencer.sv
// amo_sequencer: sequences RV32A LR.W / SC.W / AMO*.W over the shared
// ALU and data-memory port, and owns the LR/SC reservation.
// Ports:
//   clk, rst            clock, async active-high reset
//   start/amo_op/addr/rs2_data   instruction issue (captured on start)
//   mem_*               single-beat bus master (valid/ready)
//   alu_a/alu_b/alu_result       shared ALU, driven in CALC only
//   snoop_valid/snoop_addr       external writes (reservation kill)
//   rsv_clear           trap/xRET/context switch reservation drop
//   busy/done/rd_we/rd_data/misaligned   retire interface
module amo_sequencer #(
  parameter int XLEN         = 32,
  parameter int RSV_ADDR_LSB = 2,
  parameter int AMO_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AMO_OP_WIDTH-1:0] amo_op,
  input  logic [XLEN-1:0]         addr,
  input  logic [XLEN-1:0]         rs2_data,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic                    mem_ready,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    snoop_valid,
  input  logic [XLEN-1:0]         snoop_addr,
  input  logic                    rsv_clear,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_we,
  output logic [XLEN-1:0]         rd_data,
  output logic                    misaligned
);

  localparam int GW = XLEN - RSV_ADDR_LSB;

  localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_LR   = AMO_OP_WIDTH'(0);
  localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SC   = AMO_OP_WIDTH'(1);
  localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SWAP = AMO_OP_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [AMO_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [XLEN-1:0] st_q, st_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            mis_q, mis_d;
  logic            rsv_valid_q, rsv_valid_d;
  logic [GW-1:0]   rsv_addr_q, rsv_addr_d;

  logic rsv_set;
  logic sc_clr;
  logic rsv_hit;
  logic snoop_hit;

  // Snoop compares only the granule; the low bits are don't-care.
  logic unused_snoop_lsb;
  assign unused_snoop_lsb = ^snoop_addr[RSV_ADDR_LSB-1:0];

  assign rsv_hit = rsv_valid_q &&
                   (rsv_addr_q == addr[XLEN-1:RSV_ADDR_LSB]);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    rs2_d     = rs2_q;
    ld_d      = ld_q;
    st_d      = st_q;
    rd_d      = rd_q;
    mis_d     = mis_q;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;
    rsv_set   = 1'b0;
    sc_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = amo_op;
          addr_d = addr;
          rs2_d = rs2_data;
          ld_d  = '0;
          st_d  = '0;
          rd_d  = '0;
          mis_d = 1'b0;
          sc_clr = (amo_op == AMO_OP_SC);
          if (addr[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else if (amo_op == AMO_OP_SC) begin
            if (rsv_hit) begin
              st_d    = rs2_data;
              state_d = WRITE;
            end else begin
              rd_d    = XLEN'(1);
              state_d = DONE;
            end
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        if (mem_ready) begin
          ld_d = mem_rdata;
          if (op_q == AMO_OP_LR) begin
            rd_d    = mem_rdata;
            rsv_set = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        alu_a   = ld_q;
        alu_b   = rs2_q;
        st_d    = (op_q == AMO_OP_SWAP) ? rs2_q : alu_result;
        state_d = WRITE;
      end
      WRITE: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = st_q;
        if (mem_ready) begin
          rd_d    = (op_q == AMO_OP_SC) ? '0 : ld_q;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Snoop is checked against the post-set granule so that a clear
  // arriving in the same cycle as an LR set wins.
  always_comb begin
    rsv_valid_d = rsv_valid_q;
    rsv_addr_d  = rsv_addr_q;
    if (rsv_set) begin
      rsv_valid_d = 1'b1;
      rsv_addr_d  = addr_q[XLEN-1:RSV_ADDR_LSB];
    end
    snoop_hit = snoop_valid &&
                (snoop_addr[XLEN-1:RSV_ADDR_LSB] == rsv_addr_d);
    if (rsv_clear || sc_clr || snoop_hit) begin
      rsv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      ld_q        <= '0;
      st_q        <= '0;
      rd_q        <= '0;
      mis_q       <= 1'b0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
      rd_q        <= rd_d;
      mis_q       <= mis_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign rd_we      = done && !mis_q;
  assign misaligned = done && mis_q;
  assign rd_data    = rd_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: directed vectors for amo_sequencer with a bus
// responder (programmable wait states) and a reference ALU.
module tb_amo_sequencer;

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  amo_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] rs2_data = '0;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        rsv_clear = 1'b0;
  logic        busy, done, rd_we, misaligned;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];
  int wait_cfg = 0;
  int wcnt = 0;
  int nrd = 0;
  int nwr = 0;

  always #5 clk = ~clk;

  amo_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .amo_op(amo_op),
    .addr(addr), .rs2_data(rs2_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .rsv_clear(rsv_clear), .busy(busy), .done(done),
    .rd_we(rd_we), .rd_data(rd_data), .misaligned(misaligned)
  );

  assign mem_ready = mem_valid && (wcnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
    end else begin
      wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;
      if (mem_valid && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr[11:2]] <= mem_wdata;
          nwr <= nwr + 1;
        end else begin
          nrd <= nrd + 1;
        end
      end
    end
  end

  // SWAP returns garbage so the DUT must bypass the ALU for it.
  always_comb begin
    alu_result = 32'h0;
    case (amo_op)
      OP_SWAP: alu_result = 32'hBAD0BAD0;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_MIN:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      OP_MAX:  alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      OP_MINU: alu_result = (alu_a < alu_b) ? alu_a : alu_b;
      OP_MAXU: alu_result = (alu_a > alu_b) ? alu_a : alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit poke,
                       output int lat, output logic [31:0] rd,
                       output logic we, output logic mis);
    @(negedge clk);
    amo_op = op;
    addr = a;
    rs2_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      if (poke && lat == 1) begin
        start = 1'b1;
        addr = 32'h400;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
    rd = rd_data;
    we = rd_we;
    mis = misaligned;
  endtask

  int lat;
  logic [31:0] rd;
  logic we, mis;
  int r0, w0;
  bit mv_seen;

  always @(posedge clk) if (mem_valid) mv_seen <= 1'b1;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h200 >> 2] = 32'd7;
    mem[32'h204 >> 2] = 32'hFFFFFFFF;
    mem[32'h208 >> 2] = 32'd3;
    mem[32'h300 >> 2] = 32'h000000F0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // LR.W
    r0 = nrd; w0 = nwr;
    do_op(OP_LR, 32'h100, 32'h0, 1'b0, lat, rd, we, mis);
    check("lr_lat", lat, 2);
    check("lr_rd", rd, 32'hDEADBEEF);
    check("lr_we", {31'd0, we}, 32'd1);
    check("lr_reads", nrd - r0, 1);

    // SC success then repeat SC fails
    r0 = nrd; w0 = nwr;
    do_op(OP_SC, 32'h100, 32'h55, 1'b0, lat, rd, we, mis);
    check("sc_lat", lat, 2);
    check("sc_rd", rd, 32'd0);
    check("sc_mem", mem[32'h100 >> 2], 32'h55);
    check("sc_writes", nwr - w0, 1);
    w0 = nwr;
    do_op(OP_SC, 32'h100, 32'h66, 1'b0, lat, rd, we, mis);
    check("sc2_lat", lat, 1);
    check("sc2_rd", rd, 32'd1);
    check("sc2_writes", nwr - w0, 0);

    // Snoop in same granule kills reservation
    do_op(OP_LR, 32'h100, 32'h0, 1'b0, lat, rd, we, mis);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_addr = 32'h102;
    @(negedge clk);
    snoop_valid = 1'b0;
    r0 = nrd; w0 = nwr;
    do_op(OP_SC, 32'h100, 32'h77, 1'b0, lat, rd, we, mis);
    check("snoop_sc_rd", rd, 32'd1);
    check("snoop_sc_beats", (nrd - r0) + (nwr - w0), 0);

    // rsv_clear drops reservation
    do_op(OP_LR, 32'h100, 32'h0, 1'b0, lat, rd, we, mis);
    @(negedge clk);
    rsv_clear = 1'b1;
    @(negedge clk);
    rsv_clear = 1'b0;
    do_op(OP_SC, 32'h100, 32'h77, 1'b0, lat, rd, we, mis);
    check("clr_sc_rd", rd, 32'd1);

    // SC to another granule fails
    do_op(OP_LR, 32'h100, 32'h0, 1'b0, lat, rd, we, mis);
    do_op(OP_SC, 32'h104, 32'h77, 1'b0, lat, rd, we, mis);
    check("sc_other_rd", rd, 32'd1);

    // AMOADD
    r0 = nrd; w0 = nwr;
    do_op(OP_ADD, 32'h200, 32'd5, 1'b0, lat, rd, we, mis);
    check("add_lat", lat, 4);
    check("add_rd", rd, 32'd7);
    check("add_mem", mem[32'h200 >> 2], 32'd12);
    check("add_beats", (nrd - r0) * 16 + (nwr - w0), 32'h11);

    // AMOMAXU with a stray start while busy
    r0 = nrd; w0 = nwr;
    do_op(OP_MAXU, 32'h204, 32'd1, 1'b1, lat, rd, we, mis);
    check("maxu_rd", rd, 32'hFFFFFFFF);
    check("maxu_mem", mem[32'h204 >> 2], 32'hFFFFFFFF);
    check("maxu_beats", (nrd - r0) * 16 + (nwr - w0), 32'h11);
    @(negedge clk);
    check("maxu_idle", {31'd0, busy}, 32'd0);

    // AMOSWAP aligned: write rs2, not ALU output
    do_op(OP_SWAP, 32'h208, 32'd9, 1'b0, lat, rd, we, mis);
    check("swap_rd", rd, 32'd3);
    check("swap_mem", mem[32'h208 >> 2], 32'd9);

    // AMOSWAP misaligned
    @(negedge clk);
    mv_seen = 1'b0;
    do_op(OP_SWAP, 32'h203, 32'd1, 1'b0, lat, rd, we, mis);
    check("mis_lat", lat, 1);
    check("mis_flag", {31'd0, mis}, 32'd1);
    check("mis_rd_we", {31'd0, we}, 32'd0);
    check("mis_no_bus", {31'd0, mv_seen}, 32'd0);

    // AMOOR with 3 wait states, reset during WRITE
    do_op(OP_LR, 32'h100, 32'h0, 1'b0, lat, rd, we, mis);
    wait_cfg = 3;
    w0 = nwr;
    @(negedge clk);
    amo_op = OP_OR;
    addr = 32'h300;
    rs2_data = 32'h0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!(mem_valid && mem_we) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("or_reach_write", {31'd0, mem_valid && mem_we}, 32'd1);
    check("or_wdata", mem_wdata, 32'hFF);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rd_data", rd_data, 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cfg = 0;
    check("arst_no_write", nwr - w0, 0);
    check("arst_mem", mem[32'h300 >> 2], 32'hF0);
    do_op(OP_SC, 32'h100, 32'h99, 1'b0, lat, rd, we, mis);
    check("arst_sc_rd", rd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
